trig_sampler: RTL and testbench

Parametrised successor to the scope acquisition state machine. It captures DATA_W-bit ADC samples at a programmable rate into a 2^DEPTH_LOG2 circular sample RAM, with programmable pre-trigger depth, trigger level, edge polarity and an auto-trigger timeout. Single clock domain: the ADC clock is a registered output and sampling uses an internal strobe, with no derived clocks. Sits between the ADC pins and the sample RAM, and is controlled by the top-level sequencer.

---
 rtl/sampler_pkg.sv | 16 +
 rtl/sample_clk_div.sv | 42 ++++
 rtl/trig_sampler.sv | 158 +++++++++++++++
 tb/tb_trig_sampler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sampler_pkg.sv
// Shared types and constants for the trigger sampler: acquisition states and
// edge-polarity encodings.
package sampler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_DONE      = 3'd4
    } sampler_state_t;

    localparam logic TRIG_RISING  = 1'b1;
    localparam logic TRIG_FALLING = 1'b0;

endpackage

// File: rtl/sample_clk_div.sv
// Sample-rate divider: counts 0..D (D = max(clk_div,1)), drives a registered ADC
// clock that is high for the first half of the period and strobes at the count D.
module sample_clk_div #(
    parameter int DIV_W = 16
) (
    input  logic             clk_50mhz,
    input  logic             reset,
    input  logic             enable,
    input  logic [DIV_W-1:0] clk_div,
    output logic             adc_clk,
    output logic             strobe
);

    logic [DIV_W-1:0] period;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] cnt_next;
    logic             running;

    assign period   = (clk_div == '0) ? {{(DIV_W-1){1'b0}}, 1'b1} : clk_div;
    assign strobe   = running && (div_cnt == period);
    assign cnt_next = (running && (div_cnt != period)) ? div_cnt + 1'b1 : '0;

    // enable is the next-cycle run request, so adc_clk is already valid on the
    // first running cycle instead of lagging one clock behind div_cnt.
    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            running <= 1'b0;
            div_cnt <= '0;
            adc_clk <= 1'b0;
        end else begin
            running <= enable;
            if (enable) begin
                div_cnt <= cnt_next;
                adc_clk <= (cnt_next <= (period >> 1));
            end else begin
                div_cnt <= '0;
                adc_clk <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/trig_sampler.sv
// Scope acquisition engine: writes ADC samples into a circular RAM with a
// programmable pre-trigger depth, level/edge trigger, forced and auto trigger.
module trig_sampler
    import sampler_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 8,
    parameter int DIV_W      = 16
) (
    input  logic                  clk_50mhz,
    input  logic                  reset,
    input  logic                  activate,
    input  logic [DIV_W-1:0]      clk_div,
    input  logic [DEPTH_LOG2-1:0] pretrig,
    input  logic [DATA_W-1:0]     trig_level,
    input  logic                  trig_edge,
    input  logic                  auto_trig,
    input  logic                  force_trig,
    output logic                  adc_clk,
    input  logic [DATA_W-1:0]     adc_data,
    output logic                  mem_we,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_data,
    output logic [DEPTH_LOG2-1:0] start_addr,
    output logic [DEPTH_LOG2-1:0] trig_addr,
    output logic                  trig_src,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            state_dbg
);

    localparam logic [DEPTH_LOG2-1:0] ADDR_MAX   = '1;
    localparam logic [DEPTH_LOG2:0]   AUTO_LIMIT = {1'b1, {DEPTH_LOG2{1'b0}}};

    sampler_state_t        state, state_next;
    logic [DIV_W-1:0]      clk_div_q;
    logic [DEPTH_LOG2-1:0] pretrig_q, wr_ptr, wr_ptr_inc, post_cnt;
    logic [DATA_W-1:0]     level_q;
    logic                  edge_q, force_pend, prev_above, prev_valid;
    logic [DEPTH_LOG2:0]   wait_cnt;
    logic                  strobe, run_next, abort, above;
    logic                  rise_hit, fall_hit, edge_hit, auto_hit, trig_hit, do_write;

    assign busy      = (state == ST_ARM) || (state == ST_WAIT_TRIG) || (state == ST_POST);
    assign done      = (state == ST_DONE);
    assign state_dbg = state;
    assign run_next  = (state_next == ST_ARM) || (state_next == ST_WAIT_TRIG) ||
                       (state_next == ST_POST);

    sample_clk_div #(.DIV_W(DIV_W)) u_clk_div (
        .clk_50mhz (clk_50mhz),
        .reset     (reset),
        .enable    (run_next),
        .clk_div   (clk_div_q),
        .adc_clk   (adc_clk),
        .strobe    (strobe)
    );

    assign abort      = busy && !activate;
    assign above      = (adc_data >= level_q);
    assign rise_hit   = prev_valid && !prev_above && above;
    assign fall_hit   = prev_valid && prev_above && !above;
    assign edge_hit   = ((edge_q == TRIG_RISING) && rise_hit) ||
                        ((edge_q == TRIG_FALLING) && fall_hit);
    assign auto_hit   = auto_trig && (wait_cnt == AUTO_LIMIT);
    assign trig_hit   = (state == ST_WAIT_TRIG) && strobe && !abort &&
                        (edge_hit || force_pend || auto_hit);
    assign do_write   = strobe && !abort &&
                        ((state == ST_ARM) || (state == ST_WAIT_TRIG) ||
                         ((state == ST_POST) && (post_cnt != '0)));
    assign wr_ptr_inc = wr_ptr + 1'b1;

    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    // POST ends on the cycle the final write is presented, so DONE never sees mem_we.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (activate) state_next = (pretrig == '0) ? ST_WAIT_TRIG : ST_ARM;
            ST_ARM:       if (abort) state_next = ST_IDLE;
                          else if (do_write && (wr_ptr_inc == pretrig_q)) state_next = ST_WAIT_TRIG;
            ST_WAIT_TRIG: if (abort) state_next = ST_IDLE;
                          else if (trig_hit) state_next = ST_POST;
            ST_POST:      if (abort) state_next = ST_IDLE;
                          else if (mem_we && (post_cnt == '0)) state_next = ST_DONE;
            ST_DONE:      if (!activate) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            start_addr <= '0;
            trig_addr  <= '0;
            trig_src   <= 1'b0;
            clk_div_q  <= '0;
            pretrig_q  <= '0;
            level_q    <= '0;
            edge_q     <= 1'b0;
            wr_ptr     <= '0;
            post_cnt   <= '0;
            wait_cnt   <= '0;
            force_pend <= 1'b0;
            prev_above <= 1'b0;
            prev_valid <= 1'b0;
        end else begin
            mem_we <= do_write;
            if (do_write) begin
                mem_addr <= wr_ptr;
                mem_data <= adc_data;
                wr_ptr   <= wr_ptr_inc;
            end
            if ((state == ST_IDLE) && activate) begin
                clk_div_q  <= clk_div;
                pretrig_q  <= pretrig;
                level_q    <= trig_level;
                edge_q     <= trig_edge;
                wr_ptr     <= '0;
                wait_cnt   <= '0;
                force_pend <= 1'b0;
                prev_above <= 1'b0;
                prev_valid <= 1'b0;
            end
            if (((state == ST_ARM) || (state == ST_WAIT_TRIG)) && force_trig)
                force_pend <= 1'b1;
            if ((state == ST_WAIT_TRIG) && do_write) begin
                prev_above <= above;
                prev_valid <= 1'b1;
                wait_cnt   <= wait_cnt + 1'b1;
            end
            if (trig_hit) begin
                trig_addr  <= wr_ptr;
                start_addr <= wr_ptr - pretrig_q;
                trig_src   <= edge_hit;
                post_cnt   <= ADDR_MAX - pretrig_q;
                force_pend <= 1'b0;
            end
            if ((state == ST_POST) && do_write)
                post_cnt <= post_cnt - 1'b1;
            if (abort) begin
                mem_addr   <= '0;
                mem_data   <= '0;
                wr_ptr     <= '0;
                start_addr <= '0;
                trig_addr  <= '0;
                trig_src   <= 1'b0;
                force_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_trig_sampler.sv
// Directed bench for trig_sampler: divider timing, edge/forced/auto triggers,
// ring ordering, abort and asynchronous reset.
module tb_trig_sampler;

    localparam int DATA_W     = 8;
    localparam int DEPTH_LOG2 = 8;
    localparam int DIV_W      = 16;
    localparam int DEPTH      = 256;

    // clock / reset
    logic clk_50mhz = 1'b0;
    logic reset     = 1'b0;
    always #5 clk_50mhz = ~clk_50mhz;

    logic                  activate = 1'b0;
    logic [DIV_W-1:0]      clk_div = '0;
    logic [DEPTH_LOG2-1:0] pretrig = '0;
    logic [DATA_W-1:0]     trig_level = '0;
    logic                  trig_edge = 1'b0;
    logic                  auto_trig = 1'b0;
    logic                  force_trig = 1'b0;
    logic [DATA_W-1:0]     adc_data = '0;
    logic                  adc_clk, mem_we, trig_src, busy, done;
    logic [DEPTH_LOG2-1:0] mem_addr, start_addr, trig_addr;
    logic [DATA_W-1:0]     mem_data;
    logic [2:0]            state_dbg;

    trig_sampler #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .DIV_W(DIV_W)) dut (
        .clk_50mhz  (clk_50mhz),
        .reset      (reset),
        .activate   (activate),
        .clk_div    (clk_div),
        .pretrig    (pretrig),
        .trig_level (trig_level),
        .trig_edge  (trig_edge),
        .auto_trig  (auto_trig),
        .force_trig (force_trig),
        .adc_clk    (adc_clk),
        .adc_data   (adc_data),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .start_addr (start_addr),
        .trig_addr  (trig_addr),
        .trig_src   (trig_src),
        .busy       (busy),
        .done       (done),
        .state_dbg  (state_dbg)
    );

    // scoreboard state
    int                n_checks = 0;
    int                n_errors = 0;
    int                cyc = 0;
    int                wr_count = 0;
    int                first_addr = -1;
    int                last_we_cyc = 0;
    int                done_cyc = 0;
    int                seq_idx = 0;
    logic [DATA_W-1:0] seq[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] mem_model[DEPTH];
    logic [7:0]        clk_bits, we_bits;
    logic              expired;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // One clock; records any write and advances the sample source after it.
    task automatic step_cycle();
        @(negedge clk_50mhz);
        cyc++;
        if (mem_we) begin
            if (wr_count == 0) first_addr = int'(mem_addr);
            mem_model[mem_addr] = mem_data;
            wr_count++;
            last_we_cyc = cyc;
            seq_idx++;
            adc_data = seq[(seq_idx < seq.size()) ? seq_idx : seq.size() - 1];
        end
    endtask

    task automatic start_capture(input int div, input int pre, input int level,
                                 input logic edg, input logic aut);
        clk_div    = DIV_W'(div);
        pretrig    = DEPTH_LOG2'(pre);
        trig_level = DATA_W'(level);
        trig_edge  = edg;
        auto_trig  = aut;
        wr_count   = 0;
        first_addr = -1;
        seq_idx    = 0;
        adc_data   = seq[0];
        for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
        activate = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step_cycle();
            clk_bits[i] = adc_clk;
            we_bits[i]  = mem_we;
        end
    endtask

    task automatic wait_done(input int budget, output logic timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                timed_out = 1'b0;
                done_cyc  = cyc;
                break;
            end
            step_cycle();
        end
    endtask

    task automatic end_capture();
        activate = 1'b0;
        step_cycle();
        step_cycle();
    endtask

    task automatic pulse_force();
        force_trig = 1'b1;
        step_cycle();
        force_trig = 1'b0;
    endtask

    task automatic check_result(input string tag, input int t_addr, input int s_addr,
                                input logic src, input int writes);
        check_eq({tag, "_timeout"}, 32'(expired), 0);
        check_eq({tag, "_trig_addr"}, 32'(trig_addr), 32'(t_addr));
        check_eq({tag, "_start_addr"}, 32'(start_addr), 32'(s_addr));
        check_eq({tag, "_trig_src"}, 32'(trig_src), 32'(src));
        check_eq({tag, "_writes"}, 32'(wr_count), 32'(writes));
        check_eq({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        seq = '{8'h00};
        repeat (3) @(negedge clk_50mhz);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_we", 32'(mem_we), 0);
        check_eq("rst_adc_clk", 32'(adc_clk), 0);
        check_eq("rst_state", 32'(state_dbg), 0);
        check_eq("rst_trig_addr", 32'(trig_addr), 0);
        reset = 1'b1;
        step_cycle();

        // divider: D=3 gives 2 high / 2 low, write one clock after the strobe
        seq = '{8'h30};
        start_capture(3, 0, 8'h40, 1'b0, 1'b0);
        check_eq("div3_adc_clk", 32'(clk_bits), 32'h33);
        check_eq("div3_we", 32'(we_bits), 32'h10);
        check_eq("div3_busy", 32'(busy), 1);
        end_capture();
        check_eq("div3_idle", 32'(busy), 0);
        start_capture(1, 0, 8'h40, 1'b0, 1'b0);
        check_eq("div1_adc_clk", 32'(clk_bits), 32'h55);
        check_eq("div1_we", 32'(we_bits), 32'h54);
        end_capture();
        start_capture(0, 0, 8'h40, 1'b0, 1'b0);
        check_eq("div0_adc_clk", 32'(clk_bits), 32'h55);
        check_eq("div0_we", 32'(we_bits), 32'h54);
        end_capture();

        // rising ramp, pretrig 16: trigger at 0x7F->0x80
        seq.delete();
        for (int i = 0; i < 400; i++) seq.push_back(8'(i));
        start_capture(1, 16, 8'h80, 1'b1, 1'b0);
        wait_done(2000, expired);
        check_result("ramp", 128, 112, 1'b1, 368);
        check_eq("ramp_done", 32'(done), 1);
        check_eq("ramp_first_addr", 32'(first_addr), 0);
        for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'(8'h70 + i));
        for (int i = 0; i < DEPTH; i++)
            check_eq("ramp_ring", 32'(mem_model[8'(112 + i)]), 32'(exp_q.pop_front()));
        end_capture();

        // falling edge, level 0x40: 0x50 then 0x30
        seq = '{8'h50, 8'h30};
        start_capture(1, 0, 8'h40, 1'b0, 1'b0);
        wait_done(2000, expired);
        check_result("fall", 1, 1, 1'b1, 257);
        end_capture();

        // constant 0x30, no auto: never triggers; then async reset mid-WAIT_TRIG
        seq = '{8'h30};
        start_capture(1, 0, 8'h40, 1'b0, 1'b0);
        wait_done(1200, expired);
        check_eq("const_timeout", 32'(expired), 1);
        check_eq("const_busy", 32'(busy), 1);
        check_eq("const_state", 32'(state_dbg), 2);
        #2 reset = 1'b0;
        #1;
        check_eq("areset_busy", 32'(busy), 0);
        check_eq("areset_we", 32'(mem_we), 0);
        check_eq("areset_adc_clk", 32'(adc_clk), 0);
        check_eq("areset_state", 32'(state_dbg), 0);
        activate = 1'b0;
        @(negedge clk_50mhz);
        reset = 1'b1;
        step_cycle();
        start_capture(1, 0, 8'h40, 1'b0, 1'b0);
        check_eq("areset_rearm_addr", 32'(first_addr), 0);
        check_eq("areset_rearm_writes", 32'(wr_count), 3);
        end_capture();

        // auto trigger after 256 WAIT_TRIG strobes
        start_capture(1, 0, 8'h40, 1'b0, 1'b1);
        wait_done(2000, expired);
        check_result("auto", 0, 0, 1'b0, 512);
        end_capture();

        // force during ARM of a pretrig=8 run
        start_capture(1, 8, 8'h80, 1'b1, 1'b0);
        pulse_force();
        wait_done(2000, expired);
        check_result("force8", 8, 0, 1'b0, 256);
        end_capture();

        // pretrig=255: done immediately after the trigger write
        start_capture(1, 255, 8'h80, 1'b1, 1'b0);
        pulse_force();
        wait_done(2000, expired);
        check_result("pre255", 255, 0, 1'b0, 256);
        check_eq("pre255_done_lat", 32'(done_cyc - last_we_cyc), 1);
        end_capture();

        // abort mid-POST, then clean re-arm
        start_capture(1, 0, 8'h80, 1'b1, 1'b0);
        pulse_force();
        repeat (20) step_cycle();
        check_eq("post_state", 32'(state_dbg), 3);
        check_eq("post_trig_addr", 32'(trig_addr), 4);
        activate = 1'b0;
        step_cycle();
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_done", 32'(done), 0);
        check_eq("abort_we", 32'(mem_we), 0);
        check_eq("abort_trig_addr", 32'(trig_addr), 0);
        check_eq("abort_start_addr", 32'(start_addr), 0);
        check_eq("abort_mem_addr", 32'(mem_addr), 0);
        start_capture(1, 0, 8'h80, 1'b1, 1'b0);
        check_eq("abort_rearm_addr", 32'(first_addr), 0);
        end_capture();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
